mc_ctrl_fsm: RTL and testbench
==============================

# mc_ctrl_fsm

Multicycle MIPS control unit: a Moore state machine that sequences the shared datapath (one memory port, one ALU, register file, PC and instruction register) over several clock cycles per instruction. Supports R-type, ADDI, BEQ, J, SW and LW, adds a `mem_ready` wait handshake for variable-latency memory, and flags undefined opcodes. It replaces the single-cycle main decoder in the multicycle processor top level; the existing ALU decoder still consumes `alu_op`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `opcode`  in  6  instr[31:26] from the instruction register; sampled only in DECODE.
- `mem_ready`  in  1  memory handshake; 1 = current access completes this cycle.
- `pc_we`  out  1  PC write enable (unconditional).
- `branch`  out  1  conditional PC write; datapath ANDs it with ALU zero.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU out.
- `mem_we`  out  1  memory write enable.
- `ir_we`  out  1  instruction register write enable.
- `reg_dst`  out  1  write register: 0 = rt, 1 = rd.
- `mem2reg`  out  1  write data: 0 = ALU out, 1 = memory data register.
- `we_reg`  out  1  register file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = register A.
- `alu_src_b`  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `pc_src`  out  2  00 = ALU result, 01 = ALU out register, 10 = jump target.
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = decode funct.
- `retire`  out  1  one-cycle pulse on an instruction's final cycle.
- `illegal_op`  out  1  one-cycle pulse in DECODE for an undefined opcode.
- `state`  out  4  current state encoding, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge with all enables 0.
- Outputs are a function of `state` (plus `mem_ready` where noted). Any output not listed for a state is 0.
  - FETCH: alu_src_b=01. ir_we=pc_we=1 only when mem_ready=1. Advance to DECODE on mem_ready, else hold.
  - DECODE: alu_src_b=11.
    - Next state by opcode: 000000→EXECUTE, 001000→ADDIEX, 000100→BRANCH, 000010→JUMP, 101011 or 100011→MEMADR.
    - Any other opcode → FETCH with illegal_op=1.
  - MEMADR: alu_src_a=1, alu_src_b=10. Next is MEMRD for LW, MEMWR for SW; the opcode is re-read (the IR is stable).
  - MEMRD: iord=1. Advance to MEMWB on mem_ready, else hold.
  - MEMWB: mem2reg=1, we_reg=1, retire=1 → FETCH.
  - MEMWR: iord=1, mem_we=1 held for every cycle in the state. retire=1 and → FETCH on mem_ready, else hold.
  - EXECUTE: alu_src_a=1, alu_op=10 → ALUWB.
  - ALUWB: reg_dst=1, we_reg=1, retire=1 → FETCH.
  - BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1, retire=1 → FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10 → ADDIWB.
  - ADDIWB: we_reg=1, retire=1 → FETCH.
  - JUMP: pc_src=10, pc_we=1, retire=1 → FETCH.

## Timing
- Reset: while rst_n=0 at a rising edge, state←FETCH. While rst_n=0, pc_we, ir_we, mem_we, we_reg, branch, retire and illegal_op are forced to 0. All other outputs take their FETCH values: alu_src_b=01, the rest 0.
- Reset mid-instruction abandons it. No write enable is asserted in the cycle that rst_n is low.
- Cycles per instruction with mem_ready held at 1: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3, illegal opcode 2 (no retire).
- Each wait cycle on mem_ready in FETCH, MEMRD or MEMWR adds exactly one cycle.
  - PC and IR are written exactly once per fetch, in the ready cycle.
  - No other enable changes while waiting.
- A mem_ready pulse in any state other than FETCH, MEMRD or MEMWR is ignored.
- At most one of pc_we, we_reg and mem_we is 1 in any cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with mem_ready=1 → state=0, all enables 0. Release → the first cycle shows pc_we=ir_we=1, alu_src_b=01.
- LW (opcode 100011), mem_ready=1 → state sequence 0,1,2,3,4,0. MEMWB shows mem2reg=1, we_reg=1, retire=1. Repeat with SW (101011) → sequence 0,1,2,5,0 with mem_we=1 in state 5.
- R-type (000000) then ADDI (001000) back-to-back → sequences 0,1,6,7 and 0,1,9,10. ALUWB has reg_dst=1; ADDIWB has reg_dst=0; retire pulses once per instruction.
- BEQ (000100) and J (000010) → BRANCH: branch=1, pc_src=01, alu_op=01. JUMP: pc_we=1, pc_src=10. Each takes 3 cycles.
- Wait states: mem_ready=0 for 3 cycles in FETCH, then in MEMRD for an LW → FETCH held 4 cycles with a single ir_we/pc_we pulse; the LW totals 11 cycles.
- Illegal opcode 111111 → illegal_op=1 in DECODE, next state 0, no we_reg/mem_we. Assert rst_n=0 during MEMWR → the next state is 0 and mem_we=0 in the reset cycle.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS control unit, Moore FSM sequencing the shared datapath
// with a mem_ready wait handshake and undefined-opcode detection.
module mc_ctrl_fsm (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   output logic       pc_we_o,
   output logic       branch_o,
   output logic       iord_o,
   output logic       mem_we_o,
   output logic       ir_we_o,
   output logic       reg_dst_o,
   output logic       mem2reg_o,
   output logic       we_reg_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [1:0] pc_src_o,
   output logic [1:0] alu_op_o,
   output logic       retire_o,
   output logic       illegal_op_o,
   output logic [3:0] state_o
);
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_t;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_LW   = 6'b100011;
   state_t state_q, state_d;
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end
   always_comb begin
      state_d      = FETCH;
      pc_we_o      = 1'b0;
      branch_o     = 1'b0;
      iord_o       = 1'b0;
      mem_we_o     = 1'b0;
      ir_we_o      = 1'b0;
      reg_dst_o    = 1'b0;
      mem2reg_o    = 1'b0;
      we_reg_o     = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      pc_src_o     = 2'b00;
      alu_op_o     = 2'b00;
      retire_o     = 1'b0;
      illegal_op_o = 1'b0;
      case (state_q)
         FETCH: begin
            alu_src_b_o = 2'b01;
            pc_we_o     = mem_ready_i;
            ir_we_o     = mem_ready_i;
            state_d     = mem_ready_i ? DECODE : FETCH;
         end
         DECODE: begin
            alu_src_b_o = 2'b11;
            case (opcode_i)
               OP_R:         state_d = EXECUTE;
               OP_ADDI:      state_d = ADDIEX;
               OP_BEQ:       state_d = BRANCH;
               OP_J:         state_d = JUMP;
               OP_SW, OP_LW: state_d = MEMADR;
               default:      illegal_op_o = 1'b1;
            endcase
         end
         MEMADR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            state_d     = (opcode_i == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            iord_o  = 1'b1;
            state_d = mem_ready_i ? MEMWB : MEMRD;
         end
         MEMWB: begin
            mem2reg_o = 1'b1;
            we_reg_o  = 1'b1;
            retire_o  = 1'b1;
         end
         MEMWR: begin
            iord_o   = 1'b1;
            mem_we_o = 1'b1;
            retire_o = mem_ready_i;
            state_d  = mem_ready_i ? FETCH : MEMWR;
         end
         EXECUTE: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 2'b10;
            state_d     = ALUWB;
         end
         ALUWB: begin
            reg_dst_o = 1'b1;
            we_reg_o  = 1'b1;
            retire_o  = 1'b1;
         end
         BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 2'b01;
            pc_src_o    = 2'b01;
            branch_o    = 1'b1;
            retire_o    = 1'b1;
         end
         ADDIEX: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            state_d     = ADDIWB;
         end
         ADDIWB: begin
            we_reg_o = 1'b1;
            retire_o = 1'b1;
         end
         JUMP: begin
            pc_src_o = 2'b10;
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
         end
         default: state_d = FETCH;
      endcase
      // in reset, present the quiet FETCH view so nothing is written
      if (!rst_n) begin
         pc_we_o      = 1'b0;
         branch_o     = 1'b0;
         iord_o       = 1'b0;
         mem_we_o     = 1'b0;
         ir_we_o      = 1'b0;
         reg_dst_o    = 1'b0;
         mem2reg_o    = 1'b0;
         we_reg_o     = 1'b0;
         alu_src_a_o  = 1'b0;
         alu_src_b_o  = 2'b01;
         pc_src_o     = 2'b00;
         alu_op_o     = 2'b00;
         retire_o     = 1'b0;
         illegal_op_o = 1'b0;
      end
   end
   assign state_o = state_q;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed per-cycle checks of state and the packed control word
// {pc_we,branch,iord,mem_we,ir_we,reg_dst,mem2reg,we_reg,src_a,src_b,pc_src,alu_op,retire,illegal}.
module tb_mc_ctrl_fsm;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = 6'd0;
   logic       mem_ready = 1'b1;
   logic       pc_we, branch, iord, mem_we, ir_we, reg_dst, mem2reg, we_reg, alu_src_a;
   logic [1:0] alu_src_b, pc_src, alu_op;
   logic       retire, illegal_op;
   logic [3:0] state;
   int         total = 0;
   int         bad = 0;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] AI = 6'b001000, BQ = 6'b000100, JP = 6'b000010, IL = 6'b111111;
   localparam logic [16:0] F_RDY    = {1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [16:0] F_WAIT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
   localparam logic [16:0] DEC      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
   localparam logic [16:0] DEC_ILL  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b1};
   localparam logic [16:0] MADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
   localparam logic [16:0] MRD      = {1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
   localparam logic [16:0] MWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [16:0] MWR_WAIT = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
   localparam logic [16:0] MWR_RDY  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [16:0] EXE      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b10,1'b0,1'b0};
   localparam logic [16:0] AWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [16:0] BR       = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
   localparam logic [16:0] AIEX     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
   localparam logic [16:0] AIWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
   localparam logic [16:0] JMP      = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,1'b1,1'b0};
   mc_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
      .pc_we_o(pc_we), .branch_o(branch), .iord_o(iord), .mem_we_o(mem_we), .ir_we_o(ir_we),
      .reg_dst_o(reg_dst), .mem2reg_o(mem2reg), .we_reg_o(we_reg), .alu_src_a_o(alu_src_a),
      .alu_src_b_o(alu_src_b), .pc_src_o(pc_src), .alu_op_o(alu_op), .retire_o(retire),
      .illegal_op_o(illegal_op), .state_o(state)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask
   // drive one cycle's inputs at the falling edge, check 1ns later, then step past the next rising edge
   task automatic cyc(input string tag, input logic rn, input logic [5:0] op, input logic rdy,
                      input logic [3:0] es, input logic [16:0] eo);
      rst_n = rn;
      opcode = op;
      mem_ready = rdy;
      #1;
      check({tag, ".state"}, 32'(state), 32'(es));
      check({tag, ".outs"}, 32'({pc_we,branch,iord,mem_we,ir_we,reg_dst,mem2reg,we_reg,alu_src_a,
                                 alu_src_b,pc_src,alu_op,retire,illegal_op}), 32'(eo));
      check({tag, ".excl"}, 32'(int'(pc_we) + int'(we_reg) + int'(mem_we) <= 1), 32'd1);
      @(negedge clk);
   endtask
   initial begin
      @(negedge clk);
      cyc("rst1", 1'b0, LW, 1'b1, 4'd0, F_WAIT);
      cyc("rst2", 1'b0, LW, 1'b1, 4'd0, F_WAIT);
      cyc("rst3", 1'b0, LW, 1'b1, 4'd0, F_WAIT);
      cyc("lw_f",  1'b1, LW, 1'b1, 4'd0, F_RDY);
      cyc("lw_d",  1'b1, LW, 1'b1, 4'd1, DEC);
      cyc("lw_a",  1'b1, LW, 1'b1, 4'd2, MADR);
      cyc("lw_r",  1'b1, LW, 1'b1, 4'd3, MRD);
      cyc("lw_wb", 1'b1, LW, 1'b1, 4'd4, MWB);
      cyc("sw_f",  1'b1, SW, 1'b1, 4'd0, F_RDY);
      cyc("sw_d",  1'b1, SW, 1'b1, 4'd1, DEC);
      cyc("sw_a",  1'b1, SW, 1'b1, 4'd2, MADR);
      cyc("sw_w",  1'b1, SW, 1'b1, 4'd5, MWR_RDY);
      cyc("r_f",   1'b1, RT, 1'b1, 4'd0, F_RDY);
      cyc("r_d",   1'b1, RT, 1'b0, 4'd1, DEC);
      cyc("r_x",   1'b1, RT, 1'b0, 4'd6, EXE);
      cyc("r_wb",  1'b1, RT, 1'b0, 4'd7, AWB);
      cyc("ai_f",  1'b1, AI, 1'b1, 4'd0, F_RDY);
      cyc("ai_d",  1'b1, AI, 1'b1, 4'd1, DEC);
      cyc("ai_x",  1'b1, AI, 1'b1, 4'd9, AIEX);
      cyc("ai_wb", 1'b1, AI, 1'b1, 4'd10, AIWB);
      cyc("bq_f",  1'b1, BQ, 1'b1, 4'd0, F_RDY);
      cyc("bq_d",  1'b1, BQ, 1'b1, 4'd1, DEC);
      cyc("bq_b",  1'b1, BQ, 1'b1, 4'd8, BR);
      cyc("j_f",   1'b1, JP, 1'b1, 4'd0, F_RDY);
      cyc("j_d",   1'b1, JP, 1'b1, 4'd1, DEC);
      cyc("j_j",   1'b1, JP, 1'b1, 4'd11, JMP);
      for (int i = 0; i < 3; i++) cyc("wlw_fw", 1'b1, LW, 1'b0, 4'd0, F_WAIT);
      cyc("wlw_f",  1'b1, LW, 1'b1, 4'd0, F_RDY);
      cyc("wlw_d",  1'b1, LW, 1'b1, 4'd1, DEC);
      cyc("wlw_a",  1'b1, LW, 1'b1, 4'd2, MADR);
      for (int i = 0; i < 3; i++) cyc("wlw_rw", 1'b1, LW, 1'b0, 4'd3, MRD);
      cyc("wlw_r",  1'b1, LW, 1'b1, 4'd3, MRD);
      cyc("wlw_wb", 1'b1, LW, 1'b1, 4'd4, MWB);
      cyc("il_f",  1'b1, IL, 1'b1, 4'd0, F_RDY);
      cyc("il_d",  1'b1, IL, 1'b1, 4'd1, DEC_ILL);
      cyc("rs_f",  1'b1, SW, 1'b1, 4'd0, F_RDY);
      cyc("rs_d",  1'b1, SW, 1'b1, 4'd1, DEC);
      cyc("rs_a",  1'b1, SW, 1'b1, 4'd2, MADR);
      cyc("rs_ww", 1'b1, SW, 1'b0, 4'd5, MWR_WAIT);
      cyc("rs_rst", 1'b0, SW, 1'b1, 4'd5, F_WAIT);
      cyc("rs_f2", 1'b1, SW, 1'b1, 4'd0, F_RDY);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
